mem_stage_top: RTL and testbench

- Memory-access stage of the 5-stage RV32I pipeline, between the EX/MEM register and writeback.
- Performs load/store handshakes with the data-memory port, including byte-lane steering, load extension and misalignment detection.
- Stalls upstream while memory is busy.
- Contains the MEM/WB pipeline register that feeds writeback and the forwarding bypass.

---
 rtl/mem_stage_top_if.sv | 28 ++
 rtl/mem_stage_top.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_stage_top.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_top_if.sv
// mem_stage_top_if: data-memory port between the MEM stage and data memory.
//   dmem_req_o    stage -> mem  access request
//   dmem_we_o     stage -> mem  1 = write
//   dmem_addr_o   stage -> mem  word-aligned address
//   dmem_be_o     stage -> mem  byte enables
//   dmem_wdata_o  stage -> mem  lane-replicated store data
//   dmem_ack_i    mem -> stage  access complete, rdata valid this cycle
//   dmem_rdata_i  mem -> stage  read word
// Modports: master = MEM stage, slave = data memory.
interface mem_stage_top_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_ack_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_ack_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_stage_top.sv
// mem_stage_top: memory-access stage of the 5-stage RV32I pipeline.
// Issues load/store requests on the dmem port (byte-lane steering, load
// extension, misalignment detection), stalls upstream while memory is busy,
// and holds the MEM/WB register feeding writeback and forwarding.
// Ports:
//   clk_i, rst_i (async, active-high)
//   exmem_hold_i          EX/MEM holds its content at next edge (other stalls)
//   alu_result_i .. ex_valid_i   EX/MEM register contents
//   dmem                  data-memory port (master side)
//   mem_stall_o           combinational freeze of PC, IF/ID, ID/EX, EX/MEM
//   alu_result_o .. bus_err_o    MEM/WB register
// TIMEOUT: request cycles allowed before a bus error is declared (>=2).
module mem_stage_top #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exmem_hold_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] pc_address_i,
  input  logic        regwrite_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [1:0]  memtoreg_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [2:0]  width_select_i,
  input  logic        ex_valid_i,
  mem_stage_top_if.master dmem,
  output logic        mem_stall_o,
  output logic [31:0] alu_result_o,
  output logic [31:0] mem_data_o,
  output logic        regwrite_o,
  output logic [4:0]  rd_addr_o,
  output logic [1:0]  memtoreg_o,
  output logic        mem_valid_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  function automatic logic is_aligned(input logic [1:0] w, input logic [1:0] a);
    case (w)
      2'b00:   return 1'b1;
      2'b01:   return ~a[0];
      default: return a == 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] w, input logic [1:0] a);
    case (w)
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << {a[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] w, input logic [31:0] d);
    case (w)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] w, input logic [1:0] a,
                                               input logic [31:0] rdata);
    logic        [31:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    sh  = rdata >> {a, 3'b000};
    b   = sh[7:0];
    h   = sh[15:0];
    ext = 32'sd0;
    case (w)
      3'b000:  ext = b;
      3'b001:  ext = h;
      3'b100:  ext = {24'd0, sh[7:0]};
      3'b101:  ext = {16'd0, sh[15:0]};
      default: ext = rdata;
    endcase
    return ext;
  endfunction

  state_t           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             is_mem, aligned, access, misalign;
  logic             req, stall, retire, bus_err;
  logic [31:0]      wb_data;

  logic [31:0]      alu_result_p1, mem_data_p1;
  logic             regwrite_p1, vld_p1, misaligned_p1, bus_err_p1;
  logic [4:0]       rd_addr_p1;
  logic [1:0]       memtoreg_p1;

  assign is_mem   = memread_i | memwrite_i;
  assign aligned  = is_aligned(width_select_i[1:0], alu_result_i[1:0]);
  assign access   = ex_valid_i & is_mem & aligned;
  assign misalign = ex_valid_i & is_mem & ~aligned;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE: begin
        if (stall) begin
          state_n = WAIT;
          cnt_n   = CNT_W'(1);
        end else if (retire) begin
          state_n = exmem_hold_i ? DONE : IDLE;
        end
      end
      WAIT: begin
        if (retire) begin
          state_n = exmem_hold_i ? DONE : IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (!exmem_hold_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // In WAIT the request is withdrawn once the counter reaches TIMEOUT, so a
  // late ack in that cycle is ignored and the access retires as a bus error.
  always_comb begin
    req     = 1'b0;
    retire  = 1'b0;
    bus_err = 1'b0;
    case (state_q)
      IDLE: begin
        req    = access;
        retire = ex_valid_i & ~(access & ~dmem.dmem_ack_i);
      end
      WAIT: begin
        req     = cnt_q < CNT_W'(TIMEOUT);
        bus_err = ~req;
        retire  = bus_err | dmem.dmem_ack_i;
      end
      default: ;
    endcase
    stall = req & ~dmem.dmem_ack_i;
  end

  // Request and stall are gated by rst_i so they fall immediately on reset.
  assign dmem.dmem_req_o   = req & ~rst_i;
  assign mem_stall_o       = stall & ~rst_i;
  assign dmem.dmem_we_o    = memwrite_i;
  assign dmem.dmem_addr_o  = {alu_result_i[31:2], 2'b00};
  assign dmem.dmem_be_o    = lane_be(width_select_i[1:0], alu_result_i[1:0]);
  assign dmem.dmem_wdata_o = lane_wdata(width_select_i[1:0], store_data_i);

  always_comb begin
    wb_data = 32'd0;
    if (memtoreg_i == 2'b10)
      wb_data = pc_address_i + 32'd4;
    else if (memread_i & ~misalign & ~bus_err)
      wb_data = load_extract(width_select_i, alu_result_i[1:0], dmem.dmem_rdata_i);
  end

  // MEM/WB boundary
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1        <= 1'b0;
      alu_result_p1 <= 32'd0;
      mem_data_p1   <= 32'd0;
      regwrite_p1   <= 1'b0;
      rd_addr_p1    <= 5'd0;
      memtoreg_p1   <= 2'd0;
      misaligned_p1 <= 1'b0;
      bus_err_p1    <= 1'b0;
    end else if (retire) begin
      vld_p1        <= 1'b1;
      alu_result_p1 <= alu_result_i;
      mem_data_p1   <= wb_data;
      regwrite_p1   <= regwrite_i & ~misalign & ~bus_err;
      rd_addr_p1    <= rd_addr_i;
      memtoreg_p1   <= memtoreg_i;
      misaligned_p1 <= misalign;
      bus_err_p1    <= bus_err;
    end else begin
      vld_p1        <= 1'b0;
      alu_result_p1 <= 32'd0;
      mem_data_p1   <= 32'd0;
      regwrite_p1   <= 1'b0;
      rd_addr_p1    <= 5'd0;
      memtoreg_p1   <= 2'd0;
      misaligned_p1 <= 1'b0;
      bus_err_p1    <= 1'b0;
    end
  end

  assign mem_valid_o  = vld_p1;
  assign alu_result_o = alu_result_p1;
  assign mem_data_o   = mem_data_p1;
  assign regwrite_o   = regwrite_p1;
  assign rd_addr_o    = rd_addr_p1;
  assign memtoreg_o   = memtoreg_p1;
  assign misaligned_o = misaligned_p1;
  assign bus_err_o    = bus_err_p1;

endmodule

// File: tb/tb_mem_stage_top.sv
// tb_mem_stage_top: self-checking bench for mem_stage_top. Directed cases
// followed by randomized instructions, each compared against a
// transaction-level reference model of the stage.
module tb_mem_stage_top;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        exmem_hold_i;
  logic [31:0] alu_result_i, store_data_i, pc_address_i;
  logic        regwrite_i;
  logic [4:0]  rd_addr_i;
  logic [1:0]  memtoreg_i;
  logic        memread_i, memwrite_i;
  logic [2:0]  width_select_i;
  logic        ex_valid_i;
  logic        mem_stall_o;
  logic [31:0] alu_result_o, mem_data_o;
  logic        regwrite_o;
  logic [4:0]  rd_addr_o;
  logic [1:0]  memtoreg_o;
  logic        mem_valid_o, misaligned_o, bus_err_o;

  mem_stage_top_if bus ();

  mem_stage_top #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .exmem_hold_i(exmem_hold_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .pc_address_i(pc_address_i), .regwrite_i(regwrite_i), .rd_addr_i(rd_addr_i),
    .memtoreg_i(memtoreg_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
    .width_select_i(width_select_i), .ex_valid_i(ex_valid_i), .dmem(bus),
    .mem_stall_o(mem_stall_o), .alu_result_o(alu_result_o), .mem_data_o(mem_data_o),
    .regwrite_o(regwrite_o), .rd_addr_o(rd_addr_o), .memtoreg_o(memtoreg_o),
    .mem_valid_o(mem_valid_o), .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        v, rd, wr, regw;
    bit [2:0]  w;
    bit [31:0] addr, rs2, pc, rdata;
    bit [4:0]  rda;
    bit [1:0]  mtr;
    int        lat;   // request cycles without ack before ack; >= TIMEOUT means never
    int        hold;  // cycles EX/MEM stays held after retirement
  } instr_t;

  int n_chk  = 0;
  int n_pass = 0;

  bit [31:0] obs_addr, obs_wdata;
  bit [3:0]  obs_be;
  bit        obs_we;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int sz_of(bit [2:0] w);
    if (w == 3'd0 || w == 3'd4) return 1;
    if (w == 3'd1 || w == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit [31:0] model_be(bit [2:0] w, bit [31:0] addr);
    int n = sz_of(w);
    if (n == 4) return 32'd15;
    return 32'(((1 << n) - 1) << (addr % 4));
  endfunction

  function automatic bit [31:0] model_wdata(bit [2:0] w, bit [31:0] rs2);
    int n = sz_of(w);
    if (n == 1) return (rs2 & 32'hFF) * 32'h01010101;
    if (n == 2) return (rs2 & 32'hFFFF) * 32'h00010001;
    return rs2;
  endfunction

  function automatic bit [31:0] model_load(bit [2:0] w, bit [31:0] addr, bit [31:0] rdata);
    int      n = sz_of(w);
    longint  v;
    longint  word = longint'(rdata);
    v = (word >> (8 * (addr % 4))) % (64'sd1 <<< (8 * n));
    if ((w == 3'd0 || w == 3'd1) && v >= (64'sd1 <<< (8 * n - 1)))
      v = v - (64'sd1 <<< (8 * n));
    return 32'(v);
  endfunction

  function automatic instr_t mk(bit v, bit rd, bit wr, bit [2:0] w, bit [31:0] addr,
                                bit [31:0] rs2, bit [31:0] pc, bit regw, bit [4:0] rda,
                                bit [1:0] mtr, int lat, int hold, bit [31:0] rdata);
    instr_t t;
    t.v = v; t.rd = rd; t.wr = wr; t.w = w; t.addr = addr; t.rs2 = rs2; t.pc = pc;
    t.regw = regw; t.rda = rda; t.mtr = mtr; t.lat = lat; t.hold = hold; t.rdata = rdata;
    return t;
  endfunction

  // Drives one EX/MEM instruction (called at posedge+1) until it leaves the
  // stage, plays the memory side, and compares everything with the model.
  task automatic run(input instr_t t, input string nm);
    int        n, req_n, stall_n, bad, exp_req, exp_stall;
    bit        mem, al, acc, mis, berr, done, ret, first;
    bit [31:0] ebe, ewd, edata;
    n     = sz_of(t.w);
    mem   = t.v && (t.rd || t.wr);
    al    = (t.addr % n) == 0;
    acc   = mem && al;
    mis   = mem && !al;
    berr  = acc && (t.lat >= TIMEOUT);
    ret   = t.v;
    // Memory sees the issuing cycle plus lat wait cycles, or is abandoned
    // after TIMEOUT request cycles.
    exp_req   = !acc ? 0 : ((t.lat < TIMEOUT) ? t.lat + 1 : TIMEOUT);
    exp_stall = !acc ? 0 : ((t.lat < TIMEOUT) ? t.lat : TIMEOUT);
    ebe = model_be(t.w, t.addr);
    ewd = model_wdata(t.w, t.rs2);
    if (!ret) edata = 0;
    else if (t.mtr == 2'b10) edata = t.pc + 32'd4;
    else if (t.rd && acc && !berr) edata = model_load(t.w, t.addr, t.rdata);
    else edata = 0;

    ex_valid_i = t.v; memread_i = t.rd; memwrite_i = t.wr; width_select_i = t.w;
    alu_result_i = t.addr; store_data_i = t.rs2; pc_address_i = t.pc;
    regwrite_i = t.regw; rd_addr_i = t.rda; memtoreg_i = t.mtr;
    exmem_hold_i = (t.hold > 0); bus.dmem_rdata_i = t.rdata;
    req_n = 0; stall_n = 0; bad = 0; done = 0; first = 1;
    obs_addr = 0; obs_wdata = 0; obs_be = 0; obs_we = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      bus.dmem_ack_i = (k == t.lat);
      @(negedge clk);
      if (bus.dmem_req_o === 1'b1) begin
        req_n++;
        if (first) begin
          obs_addr = bus.dmem_addr_o; obs_wdata = bus.dmem_wdata_o;
          obs_be = bus.dmem_be_o; obs_we = bus.dmem_we_o; first = 0;
        end
        if (bus.dmem_addr_o !== {t.addr[31:2], 2'b00} || bus.dmem_be_o !== ebe[3:0] ||
            bus.dmem_we_o !== t.wr || bus.dmem_wdata_o !== ewd) bad++;
      end
      if (mem_stall_o === 1'b1) stall_n++;
      else done = 1;
      @(posedge clk); #1;
    end
    bus.dmem_ack_i = 1'b0;
    chk({nm, "/finished"}, 32'(done), 32'd1);
    chk({nm, "/req_cycles"}, 32'(req_n), 32'(exp_req));
    chk({nm, "/stall_cycles"}, 32'(stall_n), 32'(exp_stall));
    chk({nm, "/req_fields"}, 32'(bad), 32'd0);
    chk({nm, "/mem_valid"}, 32'(mem_valid_o), 32'(ret));
    chk({nm, "/regwrite"}, 32'(regwrite_o), 32'(ret && t.regw && !mis && !berr));
    chk({nm, "/rd_addr"}, 32'(rd_addr_o), ret ? 32'(t.rda) : 32'd0);
    chk({nm, "/memtoreg"}, 32'(memtoreg_o), ret ? 32'(t.mtr) : 32'd0);
    chk({nm, "/alu_result"}, alu_result_o, ret ? t.addr : 32'd0);
    chk({nm, "/mem_data"}, mem_data_o, edata);
    chk({nm, "/misaligned"}, 32'(misaligned_o), 32'(ret && mis));
    chk({nm, "/bus_err"}, 32'(bus_err_o), 32'(berr));

    bad = 0;
    for (int d = 0; d < t.hold; d++) begin
      exmem_hold_i = (d < t.hold - 1);
      @(negedge clk);
      if (bus.dmem_req_o !== 1'b0 || mem_stall_o !== 1'b0) bad++;
      @(posedge clk); #1;
      if (mem_valid_o !== 1'b0 || regwrite_o !== 1'b0 || mem_data_o !== 32'd0) bad++;
    end
    if (t.hold > 0) chk({nm, "/held_bubbles"}, 32'(bad), 32'd0);
    exmem_hold_i = 1'b0;
  endtask

  task automatic drive_load(input bit [31:0] addr);
    ex_valid_i = 1'b1; memread_i = 1'b1; memwrite_i = 1'b0; width_select_i = 3'b010;
    alu_result_i = addr; regwrite_i = 1'b1; rd_addr_i = 5'd7; memtoreg_i = 2'b01;
    bus.dmem_ack_i = 1'b0;
  endtask

  function automatic bit [31:0] wb_ctl();
    return 32'({mem_valid_o, regwrite_o, misaligned_o, bus_err_o, memtoreg_o, rd_addr_o});
  endfunction

  initial begin
    instr_t t;
    bit [2:0] ld_w [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    int kind;

    rst = 1'b1; exmem_hold_i = 1'b0; store_data_i = 0; pc_address_i = 0;
    bus.dmem_rdata_i = 0;
    drive_load(32'h100);
    repeat (2) @(posedge clk);
    #1;
    chk("reset/req", 32'(bus.dmem_req_o), 32'd0);
    chk("reset/stall", 32'(mem_stall_o), 32'd0);
    chk("reset/wb_ctl", wb_ctl(), 32'd0);
    chk("reset/alu_result", alu_result_o, 32'd0);
    chk("reset/mem_data", mem_data_o, 32'd0);
    ex_valid_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // LB, zero-wait memory
    run(mk(1, 1, 0, 3'd0, 32'h103, 32'h0, 32'h0, 1, 5'd3, 2'b01, 0, 0, 32'h80FF1234), "lb");
    chk("lb/be", 32'(obs_be), 32'h8);
    chk("lb/value", mem_data_o, 32'hFFFFFF80);
    // LHU with three wait cycles
    run(mk(1, 1, 0, 3'd5, 32'h102, 32'h0, 32'h0, 1, 5'd4, 2'b01, 3, 0, 32'h80FF1234), "lhu");
    chk("lhu/addr", obs_addr, 32'h100);
    chk("lhu/value", mem_data_o, 32'h000080FF);
    // SB held by EX/MEM for four cycles
    run(mk(1, 0, 1, 3'd0, 32'h201, 32'hAB, 32'h0, 0, 5'd0, 2'b00, 0, 4, 32'h0), "sb_held");
    chk("sb/we", 32'(obs_we), 32'd1);
    chk("sb/be", 32'(obs_be), 32'h2);
    chk("sb/wdata", obs_wdata, 32'hABABABAB);
    // misaligned LW
    run(mk(1, 1, 0, 3'd2, 32'h302, 32'h0, 32'h0, 1, 5'd5, 2'b01, 0, 0, 32'h12345678), "lw_mis");
    // load never acknowledged
    run(mk(1, 1, 0, 3'd2, 32'h400, 32'h0, 32'h0, 1, 5'd6, 2'b01, 99, 0, 32'hDEADBEEF), "lw_timeout");
    // ALU op with a stray ack, then PC+4 wrap
    run(mk(1, 0, 0, 3'd2, 32'h55, 32'h0, 32'h0, 1, 5'd9, 2'b00, 0, 0, 32'h0), "alu_stray_ack");
    run(mk(1, 0, 0, 3'd0, 32'h8, 32'h0, 32'hFFFFFFFC, 1, 5'd2, 2'b10, 0, 0, 32'h0), "jal_wrap");
    // JAL, then reset while the next load is requesting
    run(mk(1, 0, 0, 3'd0, 32'h0, 32'h0, 32'h1000, 1, 5'd1, 2'b10, 0, 0, 32'h0), "jal");
    chk("jal/value", mem_data_o, 32'h1004);
    drive_load(32'h40);
    #2;
    chk("rst_issue/req_before", 32'(bus.dmem_req_o), 32'd1);
    rst = 1'b1; #1;
    chk("rst_issue/req", 32'(bus.dmem_req_o), 32'd0);
    chk("rst_issue/stall", 32'(mem_stall_o), 32'd0);
    chk("rst_issue/wb_ctl", wb_ctl(), 32'd0);
    chk("rst_issue/mem_data", mem_data_o, 32'd0);
    ex_valid_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    // reset in the middle of WAIT
    drive_load(32'h80);
    repeat (3) begin @(posedge clk); #1; end
    #2;
    chk("rst_wait/req_before", 32'(bus.dmem_req_o), 32'd1);
    chk("rst_wait/stall_before", 32'(mem_stall_o), 32'd1);
    rst = 1'b1; #1;
    chk("rst_wait/req", 32'(bus.dmem_req_o), 32'd0);
    chk("rst_wait/stall", 32'(mem_stall_o), 32'd0);
    chk("rst_wait/wb_ctl", wb_ctl(), 32'd0);
    ex_valid_i = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_wait/no_retry", 32'(bus.dmem_req_o), 32'd0);
    @(posedge clk); #1;
    run(mk(1, 1, 0, 3'd1, 32'h86, 32'h0, 32'h0, 1, 5'd8, 2'b01, 99, 1, 32'h0), "after_rst_timeout");

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      t = mk(kind != 0, 0, 0, 3'd2, $urandom, $urandom, $urandom & 32'hFFFFFFFC,
             $urandom_range(0, 1) == 1, 5'($urandom), 2'b00,
             ($urandom_range(0, 14) == 0) ? 99 : $urandom_range(0, 4),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, $urandom);
      if (kind >= 1 && kind <= 3) begin
        t.rd = 1; t.w = ld_w[$urandom_range(0, 4)]; t.mtr = 2'b01;
      end else if (kind == 4 || kind == 5) begin
        t.wr = 1; t.w = 3'($urandom_range(0, 2)); t.regw = 0;
      end else if (kind == 8) begin
        t.mtr = 2'b10;
        if ($urandom_range(0, 3) == 0) t.pc = 32'hFFFFFFFC;
      end
      run(t, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
